// File: rtl/adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
// The sum is one bit wider than the operands so the carry-out is never lost.
package adder_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int SUM_WIDTH  = DATA_WIDTH + 1;

    typedef logic [DATA_WIDTH-1:0] operand_t;
    typedef logic [SUM_WIDTH-1:0]  sum_t;

endpackage

// File: rtl/adder_full_adder.sv
// Single-bit full-adder cell; one cell per bit position of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder.sv
// Registered unsigned two-operand adder built from a ripple chain of full adders.
// The final carry becomes the result MSB, and the output is registered so in1/in2 never reach out combinationally.
module adder #(
    parameter int DATA_WIDTH = adder_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH:0]   out
);

    logic [DATA_WIDTH:0]   carry;
    logic [DATA_WIDTH-1:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // Reset clears the result immediately and discards any sum in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= {carry[DATA_WIDTH], sum};
        end
    end

endmodule

// File: tb/tb_adder.sv
// Directed and random bench for the registered adder.
// Expected sums are queued when operands are driven and checked one edge later.
module tb_adder;
    import adder_pkg::*;

    logic     clk;
    logic     rst;
    operand_t in1;
    operand_t in2;
    sum_t     out;

    int   checks = 0;
    int   fails  = 0;
    sum_t expq[$];

    adder #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .in1 (in1),
        .in2 (in2),
        .out (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against a stalled run; every wait below is on the free-running clock.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic sum_t refSum(input operand_t a, input operand_t b);
        return sum_t'(a) + sum_t'(b);
    endfunction

    task automatic compare(input string tag, input sum_t observed, input sum_t expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input operand_t a, input operand_t b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        expq.push_back(refSum(a, b));
    endtask

    task automatic checkOutput(input string tag);
        sum_t expected;
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            checks++;
            fails++;
            $error("[TB] FAIL %s: observed %h expected queued result", tag, out);
        end else begin
            expected = expq.pop_front();
            compare(tag, out, expected);
        end
    endtask

    initial begin
        operand_t ra;
        operand_t rb;

        rst = 1'b0;
        in1 = '0;
        in2 = '0;

        $display("[TB] reset pulse between edges");
        #1 rst = 1'b1;
        #1 compare("reset_async", out, 9'h000);
        #1 rst = 1'b0;
        #1 compare("reset_hold", out, 9'h000);
        expq.push_back(refSum(in1, in2));
        checkOutput("first_edge_zero");

        $display("[TB] basic sum");
        applyStimulus(8'd5, 8'd2);
        #2 compare("basic_before_edge", out, 9'h000);
        checkOutput("basic_sum");

        $display("[TB] carry-out");
        applyStimulus(8'd255, 8'd1);
        checkOutput("carry_256");
        applyStimulus(8'd255, 8'd255);
        checkOutput("carry_510");

        $display("[TB] back-to-back");
        applyStimulus(8'd1, 8'd1);
        checkOutput("b2b_2");
        applyStimulus(8'd100, 8'd27);
        checkOutput("b2b_127");
        applyStimulus(8'd128, 8'd128);
        checkOutput("b2b_256");
        compare("b2b_value_256", out, 9'h100);

        $display("[TB] mid-operation reset");
        applyStimulus(8'd255, 8'd255);
        checkOutput("pre_reset_510");
        @(negedge clk);
        #1 rst = 1'b1;
        #1 compare("midop_reset_async", out, 9'h000);
        in1 = 8'd3;
        in2 = 8'd4;
        #1 compare("midop_reset_held", out, 9'h000);
        rst = 1'b0;
        expq.push_back(refSum(in1, in2));
        checkOutput("post_reset_7");

        $display("[TB] random pairs with glitches between edges");
        for (int i = 0; i < 1000; i++) begin
            ra = operand_t'($urandom_range(0, 255));
            rb = operand_t'($urandom_range(0, 255));
            applyStimulus(ra, rb);
            #1 in1 = ~ra;
            #1 in2 = rb + 8'd1;
            #1 begin
                in1 = ra;
                in2 = rb;
            end
            checkOutput("random");
        end

        compare("queue_drained", sum_t'(expq.size()), 9'h000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
